// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM field layout, sprite range constants and the
// sprite evaluation state encoding.
package ppu_pkg;

    localparam logic [1:0] OAM_Y    = 2'd0;
    localparam logic [1:0] OAM_TILE = 2'd1;
    localparam logic [1:0] OAM_ATTR = 2'd2;
    localparam logic [1:0] OAM_X    = 2'd3;

    localparam logic [7:0] SPR_Y_LIMIT = 8'hEF;
    localparam logic [8:0] SPR_H_SHORT = 9'd9;
    localparam logic [8:0] SPR_H_TALL  = 9'd17;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRdY,
        StEvY,
        StRdB,
        StWrB,
        StFinish
    } eval_state_e;

endpackage

// File: rtl/sprite_y_in_range.sv
// Vertical range test for one sprite against a scanline; shared with the
// visibility datapath so both apply the same rule.
module sprite_y_in_range
    import ppu_pkg::*;
(
    input  logic [7:0] y,
    input  logic [7:0] eval_y,
    input  logic       tall,
    output logic       hit
);

    logic [8:0] y9;
    logic [8:0] ey9;
    logic [8:0] h;

    // 9-bit compares so a sprite near the bottom never wraps onto top lines.
    always_comb begin
        y9  = {1'b0, y};
        ey9 = {1'b0, eval_y};
        h   = tall ? SPR_H_TALL : SPR_H_SHORT;
        hit = (y < SPR_Y_LIMIT) && (ey9 >= y9 + 9'd1) && (ey9 < y9 + h);
    end

endmodule

// File: rtl/sprite_eval_ctrl.sv
// Per-scanline sprite evaluation: clears secondary OAM, scans primary OAM
// and copies up to SEC_SLOTS in-range sprites.
module sprite_eval_ctrl
    import ppu_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 64,
    parameter int unsigned SEC_SLOTS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] eval_y,
    input  logic       tall,
    output logic [7:0] oam_addr,
    output logic       oam_rd,
    input  logic [7:0] oam_data,
    output logic [4:0] sec_addr,
    output logic       sec_we,
    output logic [7:0] sec_wdata,
    output logic       busy,
    output logic       done,
    output logic [3:0] sprite_count,
    output logic       sprite0_hit,
    output logic       overflow
);

    localparam int unsigned NW = $clog2(NUM_SPRITES);
    localparam int unsigned SW = $clog2(SEC_SLOTS);
    localparam logic [SW+1:0] CLR_LAST = (SW + 2)'(SEC_SLOTS * 4 - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(NUM_SPRITES - 1);
    localparam logic [3:0]    CNT_FULL = 4'(SEC_SLOTS);

    eval_state_e     state_q, state_d;
    logic [7:0]      ey_q;
    logic            tall_q;
    logic [NW-1:0]   n_q, n_d;
    logic [1:0]      b_q, b_d;
    logic [SW+1:0]   clr_q, clr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            s0_q, s0_d;
    logic            ovf_q, ovf_d;
    logic            y_hit;
    logic            last_n;
    logic [SW-1:0]   slot;

    assign last_n       = (n_q == N_LAST);
    assign slot         = cnt_q[SW-1:0];
    assign sprite_count = cnt_q;
    assign sprite0_hit  = s0_q;
    assign overflow     = ovf_q;

    sprite_y_in_range u_range (
        .y      (oam_data),
        .eval_y (ey_q),
        .tall   (tall_q),
        .hit    (y_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ey_q    <= '0;
            tall_q  <= 1'b0;
            n_q     <= '0;
            b_q     <= '0;
            clr_q   <= '0;
            cnt_q   <= '0;
            s0_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            b_q     <= b_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            ovf_q   <= ovf_d;
            if (state_q == StIdle && start) begin
                ey_q   <= eval_y;
                tall_q <= tall;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        b_d       = b_q;
        clr_d     = clr_q;
        cnt_d     = cnt_q;
        s0_d      = s0_q;
        ovf_d     = ovf_q;
        oam_addr  = '0;
        oam_rd    = 1'b0;
        sec_addr  = '0;
        sec_we    = 1'b0;
        sec_wdata = '0;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    clr_d   = '0;
                    cnt_d   = '0;
                    s0_d    = 1'b0;
                    ovf_d   = 1'b0;
                    n_d     = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                sec_we    = 1'b1;
                sec_wdata = 8'hFF;
                sec_addr  = 5'(clr_q);
                clr_d     = clr_q + 1'b1;
                if (clr_q == CLR_LAST) begin
                    state_d = StRdY;
                end
            end
            StRdY: begin
                oam_rd   = 1'b1;
                oam_addr = 8'({n_q, OAM_Y});
                state_d  = StEvY;
            end
            StEvY: begin
                if (y_hit) begin
                    if (cnt_q < CNT_FULL) begin
                        sec_we    = 1'b1;
                        sec_addr  = 5'({slot, OAM_Y});
                        sec_wdata = oam_data;
                        if (n_q == '0) begin
                            s0_d = 1'b1;
                        end
                        b_d     = OAM_TILE;
                        state_d = StRdB;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = StFinish;
                    end
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = last_n ? StFinish : StRdY;
                end
            end
            StRdB: begin
                oam_rd   = 1'b1;
                oam_addr = 8'({n_q, b_q});
                state_d  = StWrB;
            end
            StWrB: begin
                sec_we    = 1'b1;
                sec_addr  = 5'({slot, b_q});
                sec_wdata = oam_data;
                if (b_q != OAM_X) begin
                    b_d     = b_q + 1'b1;
                    state_d = StRdB;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    n_d     = n_q + 1'b1;
                    state_d = last_n ? StFinish : StRdY;
                end
            end
            StFinish: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A reset cycle must not touch either memory.
        if (rst) begin
            oam_rd = 1'b0;
            sec_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_eval_ctrl.sv
// Randomised and directed checks of sprite_eval_ctrl against a scanline model.
module tb_sprite_eval_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] eval_y = '0;
    logic       tall = 1'b0;
    logic [7:0] oam_addr;
    logic       oam_rd;
    logic [7:0] oam_data = '0;
    logic [4:0] sec_addr;
    logic       sec_we;
    logic [7:0] sec_wdata;
    logic       busy;
    logic       done;
    logic [3:0] sprite_count;
    logic       sprite0_hit;
    logic       overflow;

    logic [7:0] oam [256];
    logic [7:0] sec_mem [32];
    int         wr_total = 0;

    int errors = 0;
    int checks = 0;

    int exp_cnt, exp_s0, exp_ovf, exp_cyc;
    int exp_sec [32];

    sprite_eval_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .eval_y       (eval_y),
        .tall         (tall),
        .oam_addr     (oam_addr),
        .oam_rd       (oam_rd),
        .oam_data     (oam_data),
        .sec_addr     (sec_addr),
        .sec_we       (sec_we),
        .sec_wdata    (sec_wdata),
        .busy         (busy),
        .done         (done),
        .sprite_count (sprite_count),
        .sprite0_hit  (sprite0_hit),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (oam_rd) oam_data <= oam[oam_addr];
        if (sec_we) begin
            sec_mem[sec_addr] <= sec_wdata;
            wr_total <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk OAM in order applying the range rule with integer maths.
    task automatic model(input int ey, input bit tl);
        int y, h;
        h = tl ? 16 : 8;
        exp_cnt = 0; exp_s0 = 0; exp_ovf = 0;
        exp_cyc = 32 + 1;
        for (int i = 0; i < 32; i++) exp_sec[i] = 255;
        for (int n = 0; n < 64; n++) begin
            y = oam[n * 4];
            if (y < 239 && ey > y && ey <= y + h) begin
                if (exp_cnt == 8) begin
                    exp_ovf = 1;
                    exp_cyc += 2;
                    break;
                end
                for (int k = 0; k < 4; k++) exp_sec[exp_cnt * 4 + k] = oam[n * 4 + k];
                if (n == 0) exp_s0 = 1;
                exp_cnt++;
                exp_cyc += 8;
            end else begin
                exp_cyc += 2;
            end
        end
    endtask

    task automatic fill_oam_ff();
        for (int i = 0; i < 256; i++) oam[i] = ((i % 4) == 0) ? 8'hFF : 8'($urandom);
    endtask

    task automatic run_eval(input string tag, input int ey, input bit tl, input bit dbl);
        int cyc, busy_bad, wr0;
        model(ey, tl);
        @(negedge clk);
        wr0 = wr_total;
        eval_y = 8'(ey);
        tall = tl;
        start = 1'b1;
        cyc = 0;
        busy_bad = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            if (!busy) busy_bad++;
            if (dbl && (cyc == 3 || cyc == 60)) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check({tag, " done_cycle"}, cyc, exp_cyc);
        check({tag, " busy_gap"}, busy_bad, 0);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " count"}, sprite_count, exp_cnt);
        check({tag, " sprite0"}, sprite0_hit, exp_s0);
        check({tag, " overflow"}, overflow, exp_ovf);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, done, 0);
        check({tag, " writes"}, wr_total - wr0, 32 + exp_cnt * 4);
        for (int i = 0; i < 32; i++) check({tag, $sformatf(" sec[%0d]", i)}, sec_mem[i], exp_sec[i]);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " count_hold"}, sprite_count, exp_cnt);
        check({tag, " ovf_hold"}, overflow, exp_ovf);
    endtask

    initial begin
        int ey, hits, bad;
        fill_oam_ff();
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst count", sprite_count, 0);
        check("rst s0", sprite0_hit, 0);
        check("rst ovf", overflow, 0);
        check("rst oam_rd", oam_rd, 0);
        check("rst sec_we", sec_we, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_eval("empty", 50, 0, 0);

        oam[0] = 20; oam[1] = 5; oam[2] = 1; oam[3] = 30;
        run_eval("s0 ey21", 21, 0, 0);
        run_eval("s0 ey29", 29, 0, 0);
        run_eval("s0 ey20", 20, 0, 0);
        run_eval("tall ey36", 36, 1, 0);
        run_eval("tall ey37", 37, 1, 0);
        oam[0] = 8'hEF;
        run_eval("y_ef", 8'hF0, 0, 0);
        oam[0] = 8'hFE;
        run_eval("y_fe", 5, 1, 0);

        fill_oam_ff();
        for (int n = 3; n <= 39; n += 4) oam[n * 4] = 100;
        run_eval("ovf", 101, 0, 0);
        run_eval("dbl_start", 101, 1, 1);

        // Abort during the slot-2 copy, then confirm a clean rerun.
        fill_oam_ff();
        for (int n = 0; n < 3; n++) oam[n * 4] = 20;
        @(negedge clk);
        eval_y = 21; tall = 0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hits = 0;
        for (int c = 0; c < 300 && hits < 2; c++) begin
            if (sec_we && sec_addr == 5'd9) hits++;
            if (hits < 2) begin
                @(posedge clk);
                #1;
            end
        end
        check("abort reached", hits, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", busy, 0);
        check("abort sec_we", sec_we, 0);
        check("abort oam_rd", oam_rd, 0);
        check("abort count", sprite_count, 0);
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (sec_we || oam_rd || busy) bad++;
        end
        check("abort quiet", bad, 0);
        run_eval("after_abort", 21, 0, 0);

        for (int r = 0; r < 25; r++) begin
            ey = $urandom_range(0, 255);
            for (int n = 0; n < 64; n++) begin
                for (int k = 1; k < 4; k++) oam[n * 4 + k] = 8'($urandom);
                if ($urandom_range(0, 9) < 3) oam[n * 4] = 8'(ey - $urandom_range(0, 17));
                else oam[n * 4] = 8'($urandom);
            end
            run_eval($sformatf("rnd%0d", r), ey, 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_eval_ctrl.md
Name: sprite_eval_ctrl

Overview:
Per-scanline sprite evaluation controller. It scans primary OAM (64 sprites × 4 bytes) and finds sprites whose vertical range covers the next scanline. It copies up to SEC_SLOTS of them into secondary OAM, which feeds the per-sprite visibility and pattern datapath. It also reports sprite count, sprite-0 presence and overflow.

Parameters:
NUM_SPRITES, 64, entries in primary OAM (power of two)
SEC_SLOTS, 8, secondary OAM sprite slots (secondary OAM size is SEC_SLOTS*4 bytes)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins evaluation for line eval_y
eval_y  in  8  scanline being evaluated; sampled on start
tall  in  1  sprite height select: 0 = 8 rows, 1 = 16 rows; sampled on start
oam_addr  out  8  primary OAM byte address
oam_rd  out  1  primary OAM read strobe; data returns on oam_data the next cycle
oam_data  in  8  primary OAM read data
sec_addr  out  5  secondary OAM byte address
sec_we  out  1  secondary OAM write enable
sec_wdata  out  8  secondary OAM write data
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when evaluation completes
sprite_count  out  4  number of sprites copied, 0..SEC_SLOTS; valid from done
sprite0_hit  out  1  OAM entry 0 is in range; valid from done
overflow  out  1  more than SEC_SLOTS sprites are in range; valid from done

Behaviour:
- Reset values: state=IDLE; all outputs 0. rst mid-evaluation aborts immediately, with no further OAM or secondary OAM accesses.
- States: IDLE, CLEAR, RD_Y, EV_Y, RD_B, WR_B, FINISH.
- IDLE: on start, latch eval_y and tall, clear sprite_count, sprite0_hit and overflow, set n=0, go to CLEAR. A start pulse while busy is ignored.
- CLEAR: run SEC_SLOTS*4 cycles (32) with sec_we=1, sec_wdata=8'hFF, sec_addr=0..31. Then go to RD_Y.
- RD_Y: oam_rd=1, oam_addr={n,2'b00}. Go to EV_Y.
- EV_Y: test oam_data as Y. The sprite is in range when:
  - Y < 8'hEF, and
  - eval_y >= Y+1, and
  - eval_y < Y+H, where H=9 when tall=0 and H=17 when tall=1.
  - All comparisons are computed in 9 bits; there is no 8-bit wrap.
- EV_Y, in range with sprite_count < SEC_SLOTS:
  - write sec_addr={slot,2'b00} with Y, where slot=sprite_count.
  - set sprite0_hit when n==0.
  - set b=1 and go to RD_B.
- EV_Y, in range with sprite_count == SEC_SLOTS: set overflow=1 and go to FINISH. The scan stops; there is no diagonal-scan emulation.
- EV_Y, not in range: advance n. If n was the last entry go to FINISH, otherwise go to RD_Y.
- RD_B: oam_rd=1, oam_addr={n,b}. Go to WR_B.
- WR_B: write oam_data to sec_addr={slot,b}.
  - If b<3: b++, go to RD_B.
  - Otherwise: sprite_count++, advance n. If n was the last entry go to FINISH, otherwise go to RD_Y.
- FINISH: done=1 for one cycle, busy drops the same cycle, return to IDLE.
- Cycle costs: out-of-range sprite 2 cycles; copied sprite 8 cycles. Worst-case total is 32 + 64*2 + 8*6 + 1 = 209 cycles, which fits within the 256-cycle evaluation window.
- The n counter is log2(NUM_SPRITES) bits. Last-entry detection is n==NUM_SPRITES-1, not counter wrap.
- sprite_count, sprite0_hit and overflow hold their values until the next start or reset.
- Each cycle has at most one sec_we and at most one oam_rd.

Decomposition:
- Shared package ppu_pkg holds:
  - OAM field offsets (Y=0, TILE=1, ATTR=2, X=3)
  - the state enum
  - SPR_Y_LIMIT=8'hEF
  - SPR_H_SHORT=9, SPR_H_TALL=17
- One combinational sub-module, sprite_y_in_range (inputs Y, eval_y, tall; output hit). The visibility datapath can reuse it so both blocks share one range rule.

Test Plan:
- All 64 OAM Y=8'hFF, start with eval_y=50 -> 32 writes of FF, done at cycle 32+128+1=161, sprite_count=0, sprite0_hit=0, overflow=0.
- OAM[0]={Y=20,tile=5,attr=1,X=30}, rest Y=FF, tall=0:
  - eval_y=21 -> sec[0..3]={20,5,1,30}, sprite_count=1, sprite0_hit=1.
  - eval_y=29 -> sprite_count=0.
  - eval_y=20 -> sprite_count=0.
- Same OAM[0], tall=1: eval_y=36 -> hit; eval_y=37 -> no hit. Y=8'hEF with eval_y=8'hF0 -> no hit. Y=8'hFE -> no 9-bit overflow false hit.
- Entries 3,7,...,39 (10 sprites) have Y=100, eval_y=101 -> sprite_count=8, overflow=1, sec holds entries 3..31 in order, scan halts at entry 35.
- rst asserted mid-copy (during WR_B of slot 2) -> next cycle busy=0, no sec_we or oam_rd. A new start then yields a clean result.
- start pulsed while busy -> ignored, results identical to a single start.
